// File: rtl/output_fifo_packer.sv
// output_fifo_packer: packs application bytes into 16-bit words behind a FWFT read port,
// with an explicit flush that pads and commits a trailing odd byte.
module output_fifo_packer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int PROG_THRESH = 256,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            din,
  input  logic                  wr_en,
  input  logic                  flush,
  output logic                  full,
  input  logic                  rd_en,
  output logic [15:0]           dout,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  pkt_ready
);
  localparam int D = DEPTH_LOG2;
  localparam logic [D:0] CAP = (D+1)'(2**D);

  logic [15:0] mem [2**D];
  logic [15:0] ram_q, mem_wd;
  logic [D:0]  wr_ptr, rd_ptr, count_next;
  logic [7:0]  hold, hold_n;
  logic        hold_valid, hv_n, flush_pending, fp_n, commit, commit_n;
  logic        rd_valid, out_valid, mem_full, accept, mem_we, pop, out_load, rd_issue;

  assign mem_full = count == CAP;
  assign full     = (mem_full & hold_valid) | flush_pending;
  assign accept   = wr_en & ~full;
  assign empty    = ~out_valid;
  assign pop      = rd_en & out_valid;
  assign out_load = rd_valid & (~out_valid | pop);
  // the RAM read stage refills whenever its word moves on to the output register
  assign rd_issue = (wr_ptr != rd_ptr) & (~rd_valid | out_load);
  assign count_next = count + (D+1)'(mem_we) - (D+1)'(pop);
  assign commit_n   = (count_next == '0) ? 1'b0 : (flush | commit);

  always_comb begin
    mem_we = 1'b0;
    mem_wd = {hold, PAD_BYTE};
    hv_n   = hold_valid;
    fp_n   = flush_pending;
    hold_n = hold;
    if (flush_pending) begin
      if (!mem_full) begin
        mem_we = 1'b1;
        hv_n   = 1'b0;
        fp_n   = 1'b0;
      end
    end else if (accept & hold_valid) begin
      mem_we = 1'b1;
      mem_wd = {hold, din};
      hv_n   = 1'b0;
    end else if (accept & flush & ~mem_full) begin
      mem_we = 1'b1;
      mem_wd = {din, PAD_BYTE};
    end else if (accept) begin
      // with memory full a flushed lone byte waits in hold for its pad write
      hold_n = din;
      hv_n   = 1'b1;
      fp_n   = flush;
    end else if (flush & hold_valid) begin
      if (mem_full) fp_n = 1'b1;
      else begin
        mem_we = 1'b1;
        hv_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[D-1:0]] <= mem_wd;
    if (rd_issue) ram_q <= mem[rd_ptr[D-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      hold          <= '0;
      hold_valid    <= 1'b0;
      flush_pending <= 1'b0;
      commit        <= 1'b0;
      count         <= '0;
      pkt_ready     <= 1'b0;
      rd_valid      <= 1'b0;
      out_valid     <= 1'b0;
      dout          <= '0;
    end else begin
      wr_ptr        <= wr_ptr + (D+1)'(mem_we);
      rd_ptr        <= rd_ptr + (D+1)'(rd_issue);
      hold          <= hold_n;
      hold_valid    <= hv_n;
      flush_pending <= fp_n;
      commit        <= commit_n;
      count         <= count_next;
      pkt_ready     <= (32'(count) >= 32'(PROG_THRESH)) | commit;
      rd_valid      <= rd_issue | (rd_valid & ~out_load);
      out_valid     <= out_load | (out_valid & ~pop);
      if (out_load) dout <= ram_q;
    end
  end
endmodule

// File: tb/tb_output_fifo_packer.sv
// tb_output_fifo_packer: directed checks of packing, flush, full and reset on a 16-word instance.
module tb_output_fifo_packer;
  logic        clk = 0, rst_n = 0, wr_en = 0, flush = 0, rd_en = 0;
  logic [7:0]  din = 0;
  logic        full, empty, pkt_ready;
  logic [15:0] dout;
  logic [4:0]  count;
  int checks = 0, errors = 0;

  output_fifo_packer #(.DEPTH_LOG2(4), .PROG_THRESH(8), .PAD_BYTE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .flush(flush), .full(full),
    .rd_en(rd_en), .dout(dout), .empty(empty), .count(count), .pkt_ready(pkt_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input logic fl = 1'b0);
    din = b; wr_en = 1; flush = fl;
    tick();
    wr_en = 0; flush = 0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    int n = 0;
    while (empty && n < 8) begin tick(); n++; end
    chk({tag, "_valid"}, empty, 0);
    chk(tag, dout, exp);
    rd_en = 1;
    tick();
    rd_en = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 1; i <= n; i++) wr(8'(i));
  endtask

  initial begin
    tick(2);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_dout", dout, 0);
    chk("rst_count", count, 0);
    chk("rst_pkt", pkt_ready, 0);
    rst_n = 1;
    tick();
    // pairs of bytes become words; FWFT latency of two edges
    wr(8'h11); wr(8'h22);
    chk("t1_empty_e2", empty, 1);
    wr(8'h33);
    chk("t1_empty_e3", empty, 1);
    wr(8'h44);
    chk("t1_empty_e4", empty, 0);
    chk("t1_dout", dout, 16'h1122);
    chk("t1_count", count, 2);
    pop_chk("t1_w0", 16'h1122);
    pop_chk("t1_w1", 16'h3344);
    tick(3);
    chk("t1_drained", empty, 1);
    chk("t1_count0", count, 0);
    // flush pads the odd byte and commits
    wr(8'hAB);
    flush = 1; tick(); flush = 0;
    tick(2);
    chk("t2_pkt", pkt_ready, 1);
    chk("t2_count", count, 1);
    pop_chk("t2_w", 16'hAB00);
    tick(2);
    chk("t2_count0", count, 0);
    chk("t2_pkt0", pkt_ready, 0);
    // fill to capacity, held byte makes it full
    fill(32);
    chk("t3_count16", count, 16);
    chk("t3_full_nohold", full, 0);
    chk("t3_pkt_thresh", pkt_ready, 1);
    wr(8'd33);
    chk("t3_full33", full, 1);
    wr(8'd34);
    chk("t3_full34", full, 1);
    chk("t3_count_ign", count, 16);
    pop_chk("t3_w1", 16'h0102);
    chk("t3_full_after_pop", full, 0);
    wr(8'd35);
    for (int k = 2; k <= 16; k++) pop_chk("t3_seq", {8'(2*k-1), 8'(2*k)});
    pop_chk("t3_last", 16'h2123);
    tick(3);
    chk("t3_empty", empty, 1);
    chk("t3_count0", count, 0);
    // flush with memory full defers the pad write
    fill(33);
    flush = 1; tick(); flush = 0;
    chk("t4_full_pend", full, 1);
    chk("t4_count", count, 16);
    pop_chk("t4_w1", 16'h0102);
    chk("t4_full_still", full, 1);
    tick();
    chk("t4_count_pad", count, 16);
    chk("t4_full_clr", full, 0);
    chk("t4_pkt", pkt_ready, 1);
    for (int k = 2; k <= 16; k++) pop_chk("t4_seq", {8'(2*k-1), 8'(2*k)});
    pop_chk("t4_last", 16'h2100);
    tick(3);
    chk("t4_empty", empty, 1);
    chk("t4_pkt0", pkt_ready, 0);
    // flush together with a write
    wr(8'h5A, 1'b1);
    pop_chk("t5_a", 16'h5A00);
    tick(3);
    chk("t5_a_only", empty, 1);
    chk("t5_a_count", count, 0);
    wr(8'h01); wr(8'h02, 1'b1);
    pop_chk("t5_b", 16'h0102);
    tick(3);
    chk("t5_b_only", empty, 1);
    chk("t5_b_count", count, 0);
    // mid-operation reset drops everything, including the held byte
    wr(8'h01); wr(8'h02); wr(8'h03);
    rst_n = 0; tick(); rst_n = 1;
    chk("t6_empty", empty, 1);
    chk("t6_count", count, 0);
    chk("t6_full", full, 0);
    chk("t6_pkt", pkt_ready, 0);
    wr(8'h77); wr(8'h88);
    tick(2);
    chk("t6_dout", dout, 16'h7788);
    chk("t6_count1", count, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
